// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered EXE-stage ALU with valid/ready on both sides.
// Optional iterative shift-add multiplier (opcodes 11..13) enabled by ALU_PIPE_MUL_EN.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_sr0,
  input  logic [DATA_W-1:0] in_sr1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_result
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int M    = DATA_W - 1;

  logic              r_out_valid;
  logic [TAG_W-1:0]  r_out_rd;
  logic [DATA_W-1:0] r_out_result;

  logic [SH_W-1:0]   w_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_ovf;
  logic              w_slt;
  logic [DATA_W-1:0] w_sra;
  logic [DATA_W-1:0] w_alu;
  logic              w_out_free;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_load;
  logic [DATA_W-1:0] w_mul_res;
  logic [TAG_W-1:0]  w_mul_rd;

  assign w_sh   = in_sr1[SH_W-1:0];
  assign w_diff = {1'b0, in_sr0} - {1'b0, in_sr1};
  // Signed less-than: sign of the difference, inverted when the subtraction overflowed.
  assign w_ovf  = (in_sr0[M] != in_sr1[M]) && (w_diff[M] != in_sr0[M]);
  assign w_slt  = w_diff[M] ^ w_ovf;
  assign w_sra  = $unsigned($signed(in_sr0) >>> w_sh);

  always_comb begin
    w_alu = '0;
    case (in_op)
      4'd0:    w_alu = in_sr0 + in_sr1;
      4'd1:    w_alu = w_diff[DATA_W-1:0];
      4'd2:    w_alu = {{(DATA_W-1){1'b0}}, w_slt};
      4'd3:    w_alu = {{(DATA_W-1){1'b0}}, w_diff[DATA_W]};
      4'd4:    w_alu = in_sr0 & in_sr1;
      4'd5:    w_alu = in_sr0 | in_sr1;
      4'd6:    w_alu = ~(in_sr0 | in_sr1);
      4'd7:    w_alu = in_sr0 ^ in_sr1;
      4'd8:    w_alu = in_sr0 << w_sh;
      4'd9:    w_alu = in_sr0 >> w_sh;
      4'd10:   w_alu = w_sra;
      default: w_alu = '0;
    endcase
  end

  assign w_out_free = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [SH_W-1:0]     r_cnt;
  logic [DATA_W-1:0]   r_mcand;
  logic [2*DATA_W-1:0] r_prod;
  logic                r_neg;
  logic                r_hi;
  logic [TAG_W-1:0]    r_mul_rd;
  logic [DATA_W:0]     w_add;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_mag0;
  logic [DATA_W-1:0]   w_mag1;
  logic                w_signed_op;

  assign w_is_mul    = (in_op == 4'd11) || (in_op == 4'd12) || (in_op == 4'd13);
  assign w_signed_op = (in_op == 4'd12);
  assign w_mag0      = (w_signed_op && in_sr0[M]) ? -in_sr0 : in_sr0;
  assign w_mag1      = (w_signed_op && in_sr1[M]) ? -in_sr1 : in_sr1;
  assign in_ready    = !rst && (r_state == S_IDLE) && w_out_free && !flush;

  // Product register holds {partial high, remaining multiplier}; one bit retired per step.
  assign w_add      = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_mul_res  = r_hi ? w_prod_fix[2*DATA_W-1:DATA_W] : w_prod_fix[DATA_W-1:0];
  assign w_mul_rd   = r_mul_rd;
  assign w_mul_load = (r_state == S_DONE) && w_out_free && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_n = S_MUL;
      S_MUL:  if (r_cnt == SH_W'(DATA_W - 1)) w_state_n = S_DONE;
      S_DONE: if (w_out_free) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (flush) w_state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
      r_mul_rd <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_mcand  <= w_mag0;
      r_prod   <= {{DATA_W{1'b0}}, w_mag1};
      r_neg    <= w_signed_op && (in_sr0[M] ^ in_sr1[M]);
      r_hi     <= (in_op != 4'd11);
      r_mul_rd <= in_rd;
    end else if (r_state == S_MUL) begin
      r_prod <= {w_add, r_prod[DATA_W-1:1]};
      r_cnt  <= r_cnt + SH_W'(1);
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_load = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_rd   = '0;
  assign in_ready   = !rst && w_out_free && !flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_rd     <= '0;
      r_out_result <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid  <= 1'b1;
      r_out_rd     <= in_rd;
      r_out_result <= w_alu;
    end else if (w_mul_load) begin
      r_out_valid  <= 1'b1;
      r_out_rd     <= w_mul_rd;
      r_out_result <= w_mul_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_rd     = r_out_rd;
  assign out_result = r_out_result;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (DATA_W=32, TAG_W=5).
module tb_alu_pipe;
  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [TW-1:0] in_rd;
  logic [DW-1:0] in_sr0;
  logic [DW-1:0] in_sr1;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_rd;
  logic [DW-1:0] out_result;

  logic rdy_force;
  logic rdy_rand_en;
  logic rdy_rand = 1'b0;
  assign out_ready = rdy_force | (rdy_rand_en & rdy_rand);

  alu_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_sr0(in_sr0), .in_sr1(in_sr1),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_result(out_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin #1; rdy_rand = 1'($urandom_range(0, 1)); end

  typedef struct { logic [TW-1:0] rd; logic [DW-1:0] res; } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_res;
  logic [TW-1:0] hold_rd;

  // Monitor: pops the scoreboard on each consumed result and checks holds under back-pressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        checks++;
        if (out_result !== hold_res || out_rd !== hold_rd) begin
          errors++;
          $display("FAIL hold: got rd=%0d res=%h, required rd=%0d res=%h", out_rd, out_result, hold_rd, hold_res);
        end
      end
      if (out_valid && out_ready && !flush) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got rd=%0d res=%h, required no output", out_rd, out_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_result !== e.res || out_rd !== e.rd) begin
            errors++;
            $display("FAIL result: got rd=%0d res=%h, required rd=%0d res=%h", out_rd, out_result, e.rd, e.res);
          end
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_result;
      hold_rd  = out_rd;
    end
  end

  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [4:0] s;
`ifdef ALU_PIPE_MUL_EN
    logic [63:0]        pu;
    logic signed [63:0] ps;
    pu = {32'b0, a} * {32'b0, b};
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`endif
    s = b[4:0];
    case (op)
      4'd0:  model = a + b;
      4'd1:  model = a - b;
      4'd2:  model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  model = (a < b) ? 32'd1 : 32'd0;
      4'd4:  model = a & b;
      4'd5:  model = a | b;
      4'd6:  model = ~(a | b);
      4'd7:  model = a ^ b;
      4'd8:  model = a << s;
      4'd9:  model = a >> s;
      4'd10: model = $signed(a) >>> s;
`ifdef ALU_PIPE_MUL_EN
      4'd11: model = pu[31:0];
      4'd12: model = ps[63:32];
      4'd13: model = pu[63:32];
`endif
      default: model = 32'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'h1;
      2: pick = 32'hFFFFFFFF;
      3: pick = 32'h80000000;
      4: pick = 32'h7FFFFFFF;
      default: pick = $urandom;
    endcase
  endfunction

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] rd, input logic [DW-1:0] exp_res, input bit push);
    int t;
    exp_t e;
    @(posedge clk); #1;
    in_op = op; in_sr0 = a; in_sr1 = b; in_rd = rd; in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
    end else if (push) begin
      e.rd = rd; e.res = exp_res;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_op = 4'd0; in_rd = 5'd7;
    in_sr0 = 32'd1; in_sr1 = 32'd1; rdy_force = 1'b0; rdy_rand_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 0", out_result); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d, required 0", out_rd); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [3:0]  ops  [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd10, 4'd8, 4'd4,
                               4'd5, 4'd6, 4'd7, 4'd9, 4'd2, 4'd3, 4'd14, 4'd15};
    logic [31:0] av   [16] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                               32'h1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'hF0F0F0F0, 32'h80000000,
                               32'h7FFFFFFF, 32'h1, 32'h12345678, 32'h12345678};
    logic [31:0] bv   [16] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h7FFFFFFF, 32'd31,
                               32'd33, 32'hFF00FF00, 32'hFF00FF00, 32'h0, 32'hFF00FF00, 32'd4,
                               32'h80000000, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'h9ABCDEF0};
    logic [31:0] ev   [16] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 32'hFFFFFFFF,
                               32'h2, 32'hF000F000, 32'hFFF0FFF0, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h08000000,
                               32'h0, 32'h1, 32'h0, 32'h0};
    rdy_force = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(ops[i], av[i], bv[i], 5'(i), ev[i], 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL latency1 op=%0d: got out_valid=%b, required 1", ops[i], out_valid); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    rdy_force = 1'b0;
    send(4'd0, 32'd10, 32'd20, 5'd3, 32'd30, 1'b1);
    @(posedge clk); #1;
    in_op = 4'd0; in_sr0 = 32'd5; in_sr1 = 32'd6; in_rd = 5'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b, required 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd3) begin
        errors++; $display("FAIL b2b_held: got v=%b rd=%0d res=%h, required v=1 rd=3 res=1e", out_valid, out_rd, out_result);
      end
    end
    @(posedge clk); #1; rdy_force = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_throughput: got in_ready=%b, required 1", in_ready);
    end else begin
      e.rd = 5'd4; e.res = 32'd11; sb.push_back(e);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got out_valid=%b, required 1", out_valid); end
    drain();
  endtask

  task automatic test_random();
    int t;
    exp_t e;
    rdy_force = 1'b0; rdy_rand_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++) begin
      in_op = 4'($urandom_range(0, 15)); in_sr0 = pick(); in_sr1 = pick(); in_rd = 5'($urandom);
      in_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!in_ready && t < 200);
      if (!in_ready) begin
        checks++; errors++; $display("FAIL random_accept_timeout: got in_ready=0, required 1");
      end else begin
        e.rd = in_rd; e.res = model(in_op, in_sr0, in_sr1); sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    rdy_rand_en = 1'b0;
  endtask

  task automatic test_flush_held();
    rdy_force = 1'b0;
    send(4'd0, 32'd1, 32'd2, 5'd9, 32'd3, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b, required 1", out_valid); end
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    rdy_force = 1'b1;
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    logic [3:0]  ops [4] = '{4'd13, 4'd12, 4'd11, 4'd12};
    logic [31:0] av  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] bv  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3};
    logic [31:0] ev  [4] = '{32'hFFFFFFFE, 32'h0, 32'h1, 32'hFFFFFFFF};
    int k;
    int bad_rdy;
    rdy_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], av[i], bv[i], 5'(20 + i), ev[i], 1'b1);
      k = 0; bad_rdy = 0;
      do begin
        @(negedge clk); k++;
        if (!out_valid && in_ready) bad_rdy++;
      end while (!out_valid && k < 100);
      checks++; if (k != 34) begin errors++; $display("FAIL mul_latency op=%0d: got %0d, required 34", ops[i], k); end
      checks++; if (bad_rdy != 0) begin errors++; $display("FAIL mul_in_ready op=%0d: got %0d cycles high, required 0", ops[i], bad_rdy); end
    end
    drain();
  endtask

  task automatic test_flush_mul();
    int seen;
    rdy_force = 1'b1;
    send(4'd11, 32'd7, 32'd9, 5'd1, 32'd63, 1'b0);
    repeat (8) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_mul_in_ready: got %b, required 1", in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_mul_valid: got %0d cycles, required 0", seen); end
    send(4'd0, 32'd100, 32'd23, 5'd2, 32'd123, 1'b1);
    drain();
  endtask

  task automatic test_reset_mul();
    rdy_force = 1'b1;
    send(4'd11, 32'd5, 32'd7, 5'd1, 32'd35, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mul: got in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_idle: got in_ready=%b, required 1", in_ready); end
  endtask
`else
  task automatic test_reserved_mul_ops();
    rdy_force = 1'b1;
    for (int i = 11; i <= 13; i++) begin
      send(4'(i), 32'd3, 32'd4, 5'(i), 32'd0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL reserved_latency op=%0d: got out_valid=%b, required 1", i, out_valid); end
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_held();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
    test_flush_mul();
    test_reset_mul();
`else
    test_reserved_mul_ops();
`endif
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
